slot_pulser: RTL and testbench
==============================

SLOT_PULSER -- requirements
Module: slot_pulser

Interface
REQ-001 SHALL have parameter DEAD_TICKS, default 0: idle cycles inserted between every HIT and GND phase.
REQ-002 SHALL have port clk, input, 1: single system clock.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports i_ts_time_0..i_ts_time_3, input, 16 each: per-slot period in clk cycles.
REQ-005 SHALL have port i_pulse_mask, input, 4: transducer drive mask for the current slot.
REQ-006 SHALL have ports i_pulse_hit / i_pulse_gnd, input, 8 each: HIT / GND phase length in cycles.
REQ-007 SHALL have port i_pulse_count, input, 4: HIT+GND pairs per slot.
REQ-008 SHALL have port i_pulse_hush, input, 16: blanking length after the last pulse.
REQ-009 SHALL have port o_slot, output, 2: current slot, fed back to the parameter block's slot select.
REQ-010 SHALL have port o_slot_start, output, 1: strobe in cycle 0 of every slot.
REQ-011 SHALL have ports o_pulse_p / o_pulse_n, output, 4 each: HIT / GND phase drive.
REQ-012 SHALL have port o_hush, output, 1: high during blanking.
REQ-013 SHALL have port o_rx_start, output, 1: one-cycle strobe that opens the receive window.

Function
REQ-014 SHALL make the first clock edge after rst_n release cycle 0 of slot 0.
REQ-015 SHALL assert o_slot_start in cycle 0 of every slot.
REQ-016 SHALL make slot s last max(i_ts_time_s, 2) cycles, with i_ts_time_s sampled in cycle 0.
REQ-017 SHALL advance o_slot 0->1->2->3->0 on the cycle after the last cycle of a slot.
REQ-018 SHALL latch mask, hit, gnd, count and hush in cycle 0 of each slot; later input changes within that slot SHALL be ignored.
REQ-019 SHALL implement FSM states IDLE, HIT, GND, DEAD, HUSH, RXS, WAIT.
REQ-020 SHALL run IDLE in cycle 0 and enter HIT in cycle 1.
REQ-021 SHALL drive o_pulse_p = latched mask for exactly hit cycles in HIT.
REQ-022 SHALL pass through DEAD for DEAD_TICKS cycles, with all drive outputs 0, after each HIT.
REQ-023 SHALL drive o_pulse_n = latched mask for exactly gnd cycles in GND.
REQ-024 SHALL repeat HIT-(DEAD)-GND count times, then go to HUSH.
REQ-025 SHALL hold o_hush = 1 for exactly hush cycles in HUSH.
REQ-026 SHALL assert o_rx_start for one cycle in RXS, then hold in WAIT until the slot ends.
REQ-027 SHALL skip a phase whose length is 0; count = 0 SHALL skip directly to HUSH; hush = 0 SHALL assert o_rx_start immediately after the last GND.
REQ-028 SHALL NOT allow o_pulse_p and o_pulse_n to be nonzero in the same cycle.
REQ-029 SHALL, when a slot boundary arrives in any state other than WAIT, abort the sequence, force all drive, hush and rx outputs to 0, and restart at IDLE with o_slot_start.
REQ-030 SHALL still sequence timing and o_hush/o_rx_start when mask = 0, with both drive outputs held at 0.

Reset
REQ-031 SHALL, while rst_n = 0, force o_slot=0, o_slot_start=0, o_pulse_p=0, o_pulse_n=0, o_hush=0, o_rx_start=0, slot counter=0 and FSM=IDLE asynchronously.
REQ-032 SHALL, on reset asserted mid-pulse, drop the drive outputs in the same cycle without waiting for a clock edge.

Configuration
REQ-033 SHALL, with SLOT_PULSER_FRAME_CNT_EN defined, add output o_frame_cnt (16 bits, reset 0), incremented on each 3->0 slot wrap and wrapping FFFF->0.
REQ-034 SHALL, without SLOT_PULSER_FRAME_CNT_EN, omit o_frame_cnt entirely, with all other behaviour unchanged.

Structure
REQ-035 SHALL take the FSM state encoding, NUM_SLOTS=4 and the minimum slot length 2 from the shared package dscope_pkg.
REQ-036 SHALL place the slot period counter, o_slot and o_slot_start in sub-module slot_timer; the pulse FSM SHALL stay in slot_pulser.

Verification
REQ-037 SHALL test ts=100 all slots, mask=0101, hit=2, gnd=3, count=2, hush=4, DEAD_TICKS=0 -> p=0101 in cycles 1-2 and 6-7, n=0101 in cycles 3-5 and 8-10, hush in cycles 11-14, rx_start in cycle 15, next slot_start 100 cycles later.
REQ-038 SHALL test ts_time = 10/20/30/0 -> slot_start spacing 10, 20, 30, 2, and o_slot sequence 0,1,2,3,0.
REQ-039 SHALL test ts=8, hit=10, count=4 -> p high in cycles 1-7, aborted at the boundary, outputs 0 and new slot_start at cycle 8.
REQ-040 SHALL test count=0, hush=0 -> no drive, rx_start in cycle 1.
REQ-041 SHALL test rst_n pulled low during HIT -> o_pulse_p=0 with no clock edge; after release, slot 0 restarts in cycle 0.
REQ-042 SHALL test, with SLOT_PULSER_FRAME_CNT_EN and ts=2 all slots, 8 slots -> o_frame_cnt=2.

Source files
------------

// File: rtl/dscope_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dscope_pkg: shared slot/pulse constants and pulse FSM types.  Rev 1.0
// ----------------------------------------------------------------------------
package dscope_pkg;

    localparam int NUM_SLOTS    = 4;
    localparam int SLOT_W       = $clog2(NUM_SLOTS);
    localparam int MIN_SLOT_LEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HIT  = 3'd1,
        ST_GND  = 3'd2,
        ST_DEAD = 3'd3,
        ST_HUSH = 3'd4,
        ST_RXS  = 3'd5,
        ST_WAIT = 3'd6
    } pulse_state_e;

    typedef struct packed {
        pulse_state_e st;
        logic [15:0]  ph;
        logic [3:0]   pairs;
    } pulse_step_t;

endpackage
`default_nettype wire

// File: rtl/slot_pulser_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// slot_timer: per-slot period counter producing o_slot and o_slot_start.  Rev 1.0
// ----------------------------------------------------------------------------
module slot_timer
    import dscope_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_ts_time_0,
    input  logic [15:0] i_ts_time_1,
    input  logic [15:0] i_ts_time_2,
    input  logic [15:0] i_ts_time_3,
    output logic [1:0]  o_slot,
    output logic        o_slot_start,
    output logic        o_last
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_SLOT_LEN);

    logic        run_q;
    logic [15:0] cnt_q;
    logic [15:0] len_q;
    logic [1:0]  slot_q;
    logic        start_q;
    logic [15:0] ts_sel;
    logic [15:0] len_live;
    logic [15:0] len_cur;

    always_comb begin
        ts_sel = i_ts_time_0;
        case (slot_q)
            2'd1:    ts_sel = i_ts_time_1;
            2'd2:    ts_sel = i_ts_time_2;
            2'd3:    ts_sel = i_ts_time_3;
            default: ts_sel = i_ts_time_0;
        endcase
    end

    // Length is taken live in cycle 0 and held for the rest of the slot.
    assign len_live = (ts_sel < MIN_LEN) ? MIN_LEN : ts_sel;
    assign len_cur  = start_q ? len_live : len_q;
    assign o_last   = run_q && (cnt_q == len_cur - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            cnt_q   <= 16'd0;
            len_q   <= 16'd0;
            slot_q  <= 2'd0;
            start_q <= 1'b0;
        end else begin
            if (start_q)
                len_q <= len_live;
            if (!run_q) begin
                run_q   <= 1'b1;
                cnt_q   <= 16'd0;
                slot_q  <= 2'd0;
                start_q <= 1'b1;
            end else if (o_last) begin
                cnt_q   <= 16'd0;
                slot_q  <= slot_q + 2'd1;
                start_q <= 1'b1;
            end else begin
                cnt_q   <= cnt_q + 16'd1;
                start_q <= 1'b0;
            end
        end
    end

    assign o_slot       = slot_q;
    assign o_slot_start = start_q;

endmodule
`default_nettype wire

// File: rtl/slot_pulser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// slot_pulser: per-slot HIT/DEAD/GND pulse train, hush blanking and rx strobe.
// Optional SLOT_PULSER_FRAME_CNT_EN adds o_frame_cnt.  Rev 1.0
// ----------------------------------------------------------------------------
module slot_pulser #(
    parameter int DEAD_TICKS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_ts_time_0,
    input  logic [15:0] i_ts_time_1,
    input  logic [15:0] i_ts_time_2,
    input  logic [15:0] i_ts_time_3,
    input  logic [3:0]  i_pulse_mask,
    input  logic [7:0]  i_pulse_hit,
    input  logic [7:0]  i_pulse_gnd,
    input  logic [3:0]  i_pulse_count,
    input  logic [15:0] i_pulse_hush,
    output logic [1:0]  o_slot,
    output logic        o_slot_start,
    output logic [3:0]  o_pulse_p,
    output logic [3:0]  o_pulse_n,
    output logic        o_hush,
    output logic        o_rx_start
`ifdef SLOT_PULSER_FRAME_CNT_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);
    import dscope_pkg::*;

    localparam logic        HAS_DEAD = (DEAD_TICKS > 0);
    localparam logic [15:0] DEAD_M1  = HAS_DEAD ? 16'(DEAD_TICKS - 1) : 16'd0;

    logic         w_last;
    pulse_state_e state_q, state_d;
    logic [15:0]  ph_q, ph_d;
    logic [3:0]   pairs_q, pairs_d;
    logic [3:0]   mask_q, count_q;
    logic [7:0]   hit_q, gnd_q;
    logic [15:0]  hush_q;
    logic [7:0]   w_hit, w_gnd;
    logic [3:0]   w_count;
    logic [15:0]  w_hush;
    logic         w_empty;
    pulse_step_t  s_hush, s_entry, s_end, s_adead, s_ahit;

    slot_timer u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ts_time_0  (i_ts_time_0),
        .i_ts_time_1  (i_ts_time_1),
        .i_ts_time_2  (i_ts_time_2),
        .i_ts_time_3  (i_ts_time_3),
        .o_slot       (o_slot),
        .o_slot_start (o_slot_start),
        .o_last       (w_last)
    );

    // Cycle 0 decides on the live inputs; they are latched at its end.
    assign w_hit   = o_slot_start ? i_pulse_hit   : hit_q;
    assign w_gnd   = o_slot_start ? i_pulse_gnd   : gnd_q;
    assign w_count = o_slot_start ? i_pulse_count : count_q;
    assign w_hush  = o_slot_start ? i_pulse_hush  : hush_q;
    assign w_empty = (w_hit == 8'd0) && (w_gnd == 8'd0) && !HAS_DEAD;

    always_comb begin
        s_hush.st    = (w_hush != 16'd0) ? ST_HUSH : ST_RXS;
        s_hush.ph    = (w_hush != 16'd0) ? (w_hush - 16'd1) : 16'd0;
        s_hush.pairs = pairs_q;

        s_entry.pairs = pairs_q;
        if (w_hit != 8'd0) begin
            s_entry.st = ST_HIT;
            s_entry.ph = {8'd0, w_hit} - 16'd1;
        end else if (HAS_DEAD) begin
            s_entry.st = ST_DEAD;
            s_entry.ph = DEAD_M1;
        end else begin
            s_entry.st = ST_GND;
            s_entry.ph = {8'd0, w_gnd} - 16'd1;
        end

        if (pairs_q > 4'd1) begin
            s_end       = s_entry;
            s_end.pairs = pairs_q - 4'd1;
        end else begin
            s_end = s_hush;
        end

        if (w_gnd != 8'd0) begin
            s_adead.st    = ST_GND;
            s_adead.ph    = {8'd0, w_gnd} - 16'd1;
            s_adead.pairs = pairs_q;
        end else begin
            s_adead = s_end;
        end

        if (HAS_DEAD) begin
            s_ahit.st    = ST_DEAD;
            s_ahit.ph    = DEAD_M1;
            s_ahit.pairs = pairs_q;
        end else begin
            s_ahit = s_adead;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        pairs_d = pairs_q;
        if (w_last) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (o_slot_start) begin
                    if ((w_count == 4'd0) || w_empty) begin
                        {state_d, ph_d} = {s_hush.st, s_hush.ph};
                    end else begin
                        {state_d, ph_d} = {s_entry.st, s_entry.ph};
                        pairs_d = w_count;
                    end
                end
                ST_HIT:  if (ph_q != 16'd0) ph_d = ph_q - 16'd1;
                         else {state_d, ph_d, pairs_d} = s_ahit;
                ST_DEAD: if (ph_q != 16'd0) ph_d = ph_q - 16'd1;
                         else {state_d, ph_d, pairs_d} = s_adead;
                ST_GND:  if (ph_q != 16'd0) ph_d = ph_q - 16'd1;
                         else {state_d, ph_d, pairs_d} = s_end;
                ST_HUSH: if (ph_q != 16'd0) ph_d = ph_q - 16'd1;
                         else state_d = ST_RXS;
                ST_RXS:  state_d = ST_WAIT;
                default: state_d = ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ph_q    <= 16'd0;
            pairs_q <= 4'd0;
            mask_q  <= 4'd0;
            hit_q   <= 8'd0;
            gnd_q   <= 8'd0;
            count_q <= 4'd0;
            hush_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            pairs_q <= pairs_d;
            if (o_slot_start) begin
                mask_q  <= i_pulse_mask;
                hit_q   <= i_pulse_hit;
                gnd_q   <= i_pulse_gnd;
                count_q <= i_pulse_count;
                hush_q  <= i_pulse_hush;
            end
        end
    end

    // Decoded straight from the async-reset state so reset drops drive at once.
    assign o_pulse_p  = (state_q == ST_HIT) ? mask_q : 4'd0;
    assign o_pulse_n  = (state_q == ST_GND) ? mask_q : 4'd0;
    assign o_hush     = (state_q == ST_HUSH);
    assign o_rx_start = (state_q == ST_RXS);

`ifdef SLOT_PULSER_FRAME_CNT_EN
    logic [15:0] frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_q <= 16'd0;
        else if (w_last && (o_slot == 2'd3))
            frame_q <= frame_q + 16'd1;
    end

    assign o_frame_cnt = frame_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slot_pulser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_slot_pulser: scoreboard bench for slot_pulser.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_slot_pulser;

    typedef struct packed {
        logic [1:0] slot;
        logic       start;
        logic [3:0] p;
        logic [3:0] n;
        logic       hush;
        logic       rx;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ts0, ts1, ts2, ts3;
    logic [3:0]  mask, count;
    logic [7:0]  hit, gnd;
    logic [15:0] hush;
    logic [1:0]  o_slot;
    logic        o_slot_start, o_hush, o_rx_start;
    logic [3:0]  o_pulse_p, o_pulse_n;
`ifdef SLOT_PULSER_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];

    slot_pulser dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ts_time_0   (ts0),
        .i_ts_time_1   (ts1),
        .i_ts_time_2   (ts2),
        .i_ts_time_3   (ts3),
        .i_pulse_mask  (mask),
        .i_pulse_hit   (hit),
        .i_pulse_gnd   (gnd),
        .i_pulse_count (count),
        .i_pulse_hush  (hush),
        .o_slot        (o_slot),
        .o_slot_start  (o_slot_start),
        .o_pulse_p     (o_pulse_p),
        .o_pulse_n     (o_pulse_n),
        .o_hush        (o_hush),
        .o_rx_start    (o_rx_start)
`ifdef SLOT_PULSER_FRAME_CNT_EN
        ,
        .o_frame_cnt   (o_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        return {o_slot, o_slot_start, o_pulse_p, o_pulse_n, o_hush, o_rx_start};
    endfunction

    function automatic obs_t mk(logic [1:0] s, logic st, logic [3:0] p, logic [3:0] n,
                                logic h, logic rx);
        return {s, st, p, n, h, rx};
    endfunction

    task automatic set_ts(input logic [15:0] a, b, c, d);
        ts0 = a; ts1 = b; ts2 = c; ts3 = d;
    endtask

    // Release falls on a negedge: the next posedge begins cycle 0 of slot 0.
    task automatic start_run();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got;
        rst_n = 1'b0;
        set_ts(16'd5, 16'd5, 16'd5, 16'd5);
        mask = 4'hF; hit = 8'd3; gnd = 8'd3; count = 4'd2; hush = 16'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = sample();
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, got);
            end
        end
`ifdef SLOT_PULSER_FRAME_CNT_EN
        checks++;
        if (o_frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt got=%0d exp=0", o_frame_cnt);
        end
`endif
    endtask

    task automatic test_basic();
        obs_t got, exp;
        logic [3:0] p, n;
        set_ts(16'd100, 16'd100, 16'd100, 16'd100);
        mask = 4'b0101; hit = 8'd2; gnd = 8'd3; count = 4'd2; hush = 16'd4;
        for (int c = 0; c <= 100; c++) begin
            p = ((c >= 1 && c <= 2) || (c >= 6 && c <= 7)) ? 4'b0101 : 4'b0000;
            n = ((c >= 3 && c <= 5) || (c >= 8 && c <= 10)) ? 4'b0101 : 4'b0000;
            if (c == 100) sb.push_back(mk(2'd1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0));
            else sb.push_back(mk(2'd0, c == 0, p, n, c >= 11 && c <= 14, c == 15));
        end
        start_run();
        for (int c = 0; c <= 100; c++) begin
            @(negedge clk);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_train cyc=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 1) begin
                mask = 4'hF; hit = 8'd1; gnd = 8'd1; count = 4'd7; hush = 16'd50;
            end
        end
    endtask

    task automatic test_slot_times();
        obs_t got, exp;
        int lens[4] = '{10, 20, 30, 2};
        int total = 0;
        set_ts(16'd10, 16'd20, 16'd30, 16'd0);
        mask = 4'hF; hit = 8'd5; gnd = 8'd5; count = 4'd0; hush = 16'd0;
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < lens[s]; k++) begin
                sb.push_back(mk(2'(s), k == 0, 4'd0, 4'd0, 1'b0, k == 1));
                total++;
            end
        sb.push_back(mk(2'd0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0));
        total++;
        start_run();
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL slot_times cyc=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_mask_zero();
        obs_t got, exp;
        set_ts(16'd10, 16'd10, 16'd10, 16'd10);
        mask = 4'h0; hit = 8'd2; gnd = 8'd1; count = 4'd1; hush = 16'd2;
        for (int c = 0; c <= 10; c++)
            sb.push_back(mk(2'(c / 10), c == 0 || c == 10, 4'd0, 4'd0,
                            c >= 4 && c <= 5, c == 6));
        start_run();
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mask_zero cyc=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_abort();
        obs_t got, exp;
        set_ts(16'd8, 16'd8, 16'd8, 16'd8);
        mask = 4'b0011; hit = 8'd10; gnd = 8'd1; count = 4'd4; hush = 16'd1;
        for (int c = 0; c <= 9; c++)
            sb.push_back(mk(2'(c / 8), c == 0 || c == 8,
                            (c == 0 || c == 8) ? 4'd0 : 4'b0011, 4'd0, 1'b0, 1'b0));
        start_run();
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort cyc=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, exp;
        set_ts(16'd100, 16'd100, 16'd100, 16'd100);
        mask = 4'hF; hit = 8'd10; gnd = 8'd1; count = 4'd1; hush = 16'd1;
        start_run();
        repeat (4) @(negedge clk);
        checks++;
        if (o_pulse_p !== 4'hF) begin
            errors++;
            $display("FAIL mid_pre_reset_p got=%h exp=f", o_pulse_p);
        end
        #2 rst_n = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL mid_async_drop got=%h exp=0", got);
        end
        for (int c = 0; c <= 2; c++)
            sb.push_back(mk(2'd0, c == 0, (c == 0) ? 4'd0 : 4'hF, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_restart cyc=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

`ifdef SLOT_PULSER_FRAME_CNT_EN
    task automatic test_frame_cnt();
        logic [15:0] fexp[$];
        logic [15:0] e;
        set_ts(16'd2, 16'd2, 16'd2, 16'd2);
        mask = 4'h0; hit = 8'd0; gnd = 8'd0; count = 4'd0; hush = 16'd0;
        for (int c = 0; c <= 16; c++) fexp.push_back(16'(c / 8));
        start_run();
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            e = fexp.pop_front();
            checks++;
            if (o_frame_cnt !== e) begin
                errors++;
                $display("FAIL frame_cnt cyc=%0d got=%0d exp=%0d", c, o_frame_cnt, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_slot_times();
        test_mask_zero();
        test_abort();
        test_reset_mid();
`ifdef SLOT_PULSER_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
